// File: rtl/s_core_loader_pkg.sv
// -----------------------------------------------------------------------------
// s_core_loader_pkg
// Shared definitions for the s_core boot loader: frame command codes, the
// loader FSM state encoding, the decoded operation kept for the frame being
// parsed, and the sticky error codes reported on o_err.
// -----------------------------------------------------------------------------
package s_core_loader_pkg;

  // Command byte values that open a frame.
  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_REG  = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_WRITE,
    ST_RUN
  } state_t;

  // Decoded command of the frame in flight.
  typedef enum logic [1:0] {
    OP_IMEM,
    OP_REG,
    OP_RUN,
    OP_HALT
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CMD  = 2'b01,
    ERR_CSUM = 2'b10
  } err_t;

endpackage

// File: rtl/s_core_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Collects up to four stream bytes into a 32-bit little-endian word: the first
// byte lands in [7:0], the next in [15:8] and so on.
//
// Ports
//   clk       core clock
//   rst       synchronous, active-high reset
//   clear     restart the field (frame start)
//   push      insert byte_in at the current byte position
//   byte_in   stream byte
//   last_idx  index of the final byte of the field (0 = 1 byte, 3 = 4 bytes)
//   word      assembled field
//   done      the byte being pushed now completes the field
// -----------------------------------------------------------------------------
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  last_idx,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0] cnt_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= 2'd0;
      word  <= 32'd0;
    end else if (push) begin
      word[{cnt_q, 3'b000} +: 8] <= byte_in;
      cnt_q                      <= cnt_q + 2'd1;
    end
  end

  // Qualified by push so the FSM can move on in the same cycle the last byte
  // transfers, keeping one byte per cycle throughput.
  assign done = push && (cnt_q == last_idx);

endmodule

// File: rtl/s_core_loader.sv
// -----------------------------------------------------------------------------
// s_core_loader
// Boot loader in front of s_core's setup port. Parses checksummed command
// frames from a valid/ready byte stream and produces instruction-memory and
// register-file load writes, the start PC and the setup (load mode) level.
//
// Ports
//   clk, rst_n                 clock; rst_n is a synchronous ACTIVE-HIGH reset
//                              (name shared with s_core)
//   i_rx_data/valid, o_rx_ready  byte stream handshake
//   o_inst_mem_addr/data, o_inst_we  instruction load write (one-cycle strobe)
//   o_load_reg_addr/data, o_reg_we   register load write (one-cycle strobe)
//   o_pc_instr_start_addr      start PC latched by a RUN frame
//   o_setup                    1 = core held in load mode
//   o_err                      sticky error: 01 bad command, 10 bad checksum
//   o_frame_cnt                count of good frames (wraps)
// -----------------------------------------------------------------------------
module s_core_loader
  import s_core_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [31:0]      o_inst_mem_addr,
  output logic [31:0]      o_inst_mem_data,
  output logic             o_inst_we,
  output logic [4:0]       o_load_reg_addr,
  output logic [31:0]      o_load_reg_data,
  output logic             o_reg_we,
  output logic [31:0]      o_pc_instr_start_addr,
  output logic             o_setup,
  output logic [1:0]       o_err,
  output logic [CNT_W-1:0] o_frame_cnt
);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [7:0]  csum_q, csum_d;

  logic        xfer;
  logic        frame_start, addr_push, data_push;
  logic        csum_ok, csum_bad, cmd_bad;
  logic [1:0]  addr_last;
  logic [31:0] addr_word, data_word;
  logic        addr_done, data_done;

  // WRITE is the single bubble cycle per frame; nothing is accepted in reset.
  assign o_rx_ready = !rst_n && (state_q != ST_WRITE);
  assign xfer       = i_rx_valid && o_rx_ready;
  assign addr_last  = (op_q == OP_REG) ? 2'd0 : 2'd3;

  byte_assembler u_addr_asm (
    .clk      (clk),
    .rst      (rst_n),
    .clear    (frame_start),
    .push     (addr_push),
    .byte_in  (i_rx_data),
    .last_idx (addr_last),
    .word     (addr_word),
    .done     (addr_done)
  );

  byte_assembler u_data_asm (
    .clk      (clk),
    .rst      (rst_n),
    .clear    (frame_start),
    .push     (data_push),
    .byte_in  (i_rx_data),
    .last_idx (2'd3),
    .word     (data_word),
    .done     (data_done)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    csum_d      = csum_q;
    frame_start = 1'b0;
    addr_push   = 1'b0;
    data_push   = 1'b0;
    csum_ok     = 1'b0;
    csum_bad    = 1'b0;
    cmd_bad     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          csum_d = i_rx_data;
          case (i_rx_data)
            CMD_IMEM: begin op_d = OP_IMEM; state_d = ST_ADDR; frame_start = 1'b1; end
            CMD_REG:  begin op_d = OP_REG;  state_d = ST_ADDR; frame_start = 1'b1; end
            CMD_RUN:  begin op_d = OP_RUN;  state_d = ST_ADDR; frame_start = 1'b1; end
            CMD_HALT: begin op_d = OP_HALT; state_d = ST_CSUM; frame_start = 1'b1; end
            default:  cmd_bad = 1'b1;
          endcase
        end
      end

      ST_ADDR: begin
        if (xfer) begin
          addr_push = 1'b1;
          csum_d    = csum_q ^ i_rx_data;
          if (addr_done) state_d = (op_q == OP_RUN) ? ST_CSUM : ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
          data_push = 1'b1;
          csum_d    = csum_q ^ i_rx_data;
          if (data_done) state_d = ST_CSUM;
        end
      end

      ST_CSUM: begin
        if (xfer) begin
          if (i_rx_data == csum_q) begin
            csum_ok = 1'b1;
            state_d = ST_WRITE;
          end else begin
            csum_bad = 1'b1;
            // A corrupted HALT leaves a running core running.
            state_d  = o_setup ? ST_IDLE : ST_RUN;
          end
        end
      end

      ST_WRITE: state_d = (op_q == OP_RUN) ? ST_RUN : ST_IDLE;

      ST_RUN: begin
        if (xfer) begin
          if (i_rx_data == CMD_HALT) begin
            op_d        = OP_HALT;
            csum_d      = i_rx_data;
            frame_start = 1'b1;
            state_d     = ST_CSUM;
          end else begin
            cmd_bad = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are updated on the edge where a good checksum byte transfers, so
  // they become visible during the WRITE bubble cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q               <= ST_IDLE;
      op_q                  <= OP_IMEM;
      csum_q                <= 8'd0;
      o_inst_mem_addr       <= 32'd0;
      o_inst_mem_data       <= 32'd0;
      o_inst_we             <= 1'b0;
      o_load_reg_addr       <= 5'd0;
      o_load_reg_data       <= 32'd0;
      o_reg_we              <= 1'b0;
      o_pc_instr_start_addr <= 32'd0;
      o_setup               <= 1'b1;
      o_err                 <= ERR_NONE;
      o_frame_cnt           <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      csum_q    <= csum_d;
      o_inst_we <= 1'b0;
      o_reg_we  <= 1'b0;

      if (cmd_bad)  o_err <= ERR_CMD;
      if (csum_bad) o_err <= ERR_CSUM;

      if (csum_ok) begin
        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
        case (op_q)
          OP_IMEM: begin
            o_inst_mem_addr <= addr_word;
            o_inst_mem_data <= data_word;
            o_inst_we       <= 1'b1;
          end
          OP_REG: begin
            o_load_reg_addr <= addr_word[4:0];
            o_load_reg_data <= data_word;
            o_reg_we        <= 1'b1;
          end
          OP_RUN: begin
            o_pc_instr_start_addr <= addr_word;
            o_setup               <= 1'b0;
          end
          default: o_setup <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s_core_loader.sv
// -----------------------------------------------------------------------------
// tb_s_core_loader
// Directed frames with hand-computed expected values, played once back-to-back
// and once with random idle gaps on i_rx_valid.
// -----------------------------------------------------------------------------
module tb_s_core_loader;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             o_rx_ready;
  logic [31:0]      o_inst_mem_addr;
  logic [31:0]      o_inst_mem_data;
  logic             o_inst_we;
  logic [4:0]       o_load_reg_addr;
  logic [31:0]      o_load_reg_data;
  logic             o_reg_we;
  logic [31:0]      o_pc_instr_start_addr;
  logic             o_setup;
  logic [1:0]       o_err;
  logic [CNT_W-1:0] o_frame_cnt;

  always #5 clk = ~clk;

  s_core_loader #(.CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_rx_data             (i_rx_data),
    .i_rx_valid            (i_rx_valid),
    .o_rx_ready            (o_rx_ready),
    .o_inst_mem_addr       (o_inst_mem_addr),
    .o_inst_mem_data       (o_inst_mem_data),
    .o_inst_we             (o_inst_we),
    .o_load_reg_addr       (o_load_reg_addr),
    .o_load_reg_data       (o_load_reg_data),
    .o_reg_we              (o_reg_we),
    .o_pc_instr_start_addr (o_pc_instr_start_addr),
    .o_setup               (o_setup),
    .o_err                 (o_err),
    .o_frame_cnt           (o_frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit use_gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe monitor: counts pulses, overlapping strobes and strobes longer than one cycle.
  int   inst_pulses = 0;
  int   reg_pulses  = 0;
  int   bad_strobes = 0;
  logic inst_prev   = 1'b0;
  logic reg_prev    = 1'b0;

  always @(negedge clk) begin
    if (o_inst_we) inst_pulses <= inst_pulses + 1;
    if (o_reg_we)  reg_pulses  <= reg_pulses + 1;
    if ((o_inst_we && o_reg_we) || (o_inst_we && inst_prev) || (o_reg_we && reg_prev))
      bad_strobes <= bad_strobes + 1;
    inst_prev <= o_inst_we;
    reg_prev  <= o_reg_we;
  end

  // Called just after a rising edge; returns just after the edge that transfers b.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int gap;
    gap        = use_gaps ? int'($urandom_range(0, 3)) : 0;
    i_rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    ok         = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (o_rx_ready) ok = 1'b1;
    end
    if (!ok) check("rx_ready_timeout", {31'd0, o_rx_ready}, 32'd1);
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  // Frame bytes written left to right in the literal; the first byte is the most significant.
  task automatic send_frame(input logic [79:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b1;   // active-high despite the name
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h01;  // must not be consumed
    @(negedge clk);
    check("reset_ready", {31'd0, o_rx_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_inst_addr", o_inst_mem_addr, 32'd0);
    check("reset_inst_data", o_inst_mem_data, 32'd0);
    check("reset_reg_addr",  {27'd0, o_load_reg_addr}, 32'd0);
    check("reset_reg_data",  o_load_reg_data, 32'd0);
    check("reset_pc",        o_pc_instr_start_addr, 32'd0);
    check("reset_strobes",   {30'd0, o_inst_we, o_reg_we}, 32'd0);
    check("reset_setup",     {31'd0, o_setup}, 32'd1);
    check("reset_err",       {30'd0, o_err}, 32'd0);
    check("reset_cnt",       {16'd0, o_frame_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n      = 1'b0;
    i_rx_valid = 1'b0;
  endtask

  initial begin
    int base_inst, base_reg, snap_inst;
    rst_n      = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    realign();

    for (int pass = 0; pass < 2; pass++) begin
      use_gaps = (pass == 1);
      apply_reset();
      base_inst = inst_pulses;
      base_reg  = reg_pulses;

      // IMEM addr 4, data 0x00127413
      send_frame(80'h01_04_00_00_00_13_74_12_00_70, 10);
      @(negedge clk);
      check("imem_we",    {31'd0, o_inst_we}, 32'd1);
      check("imem_addr",  o_inst_mem_addr, 32'h0000_0004);
      check("imem_data",  o_inst_mem_data, 32'h0012_7413);
      check("imem_cnt",   {16'd0, o_frame_cnt}, 32'd1);
      check("imem_bubble_ready", {31'd0, o_rx_ready}, 32'd0);
      check("imem_no_reg_we", {31'd0, o_reg_we}, 32'd0);
      realign();

      // REG index 4 = 1
      send_frame(80'h02_04_01_00_00_00_07, 7);
      @(negedge clk);
      check("reg_we",        {31'd0, o_reg_we}, 32'd1);
      check("reg_addr",      {27'd0, o_load_reg_addr}, 32'd4);
      check("reg_data",      o_load_reg_data, 32'h0000_0001);
      check("reg_cnt",       {16'd0, o_frame_cnt}, 32'd2);
      check("reg_imem_hold", o_inst_mem_addr, 32'h0000_0004);
      realign();

      // RUN at 0x4
      send_frame(80'h03_04_00_00_00_07, 6);
      @(negedge clk);
      check("run_setup",   {31'd0, o_setup}, 32'd0);
      check("run_pc",      o_pc_instr_start_addr, 32'h0000_0004);
      check("run_strobes", {30'd0, o_inst_we, o_reg_we}, 32'd0);
      check("run_cnt",     {16'd0, o_frame_cnt}, 32'd3);
      realign();

      // Non-HALT byte while running is rejected
      send_byte(8'h01);
      @(negedge clk);
      check("run_badcmd_err",   {30'd0, o_err}, 32'd1);
      check("run_badcmd_setup", {31'd0, o_setup}, 32'd0);
      realign();

      // HALT returns to setup
      send_frame(80'h04_04, 2);
      @(negedge clk);
      check("halt_setup", {31'd0, o_setup}, 32'd1);
      check("halt_cnt",   {16'd0, o_frame_cnt}, 32'd4);
      realign();

      // IMEM with bad checksum
      send_frame(80'h01_04_00_00_00_13_74_12_00_71, 10);
      @(negedge clk);
      check("badcs_we",    {31'd0, o_inst_we}, 32'd0);
      check("badcs_err",   {30'd0, o_err}, 32'd2);
      check("badcs_cnt",   {16'd0, o_frame_cnt}, 32'd4);
      check("badcs_setup", {31'd0, o_setup}, 32'd1);
      realign();

      // Following good IMEM: addr 8, data 0xDDCCBBAA
      send_frame(80'h01_08_00_00_00_AA_BB_CC_DD_09, 10);
      @(negedge clk);
      check("imem2_we",   {31'd0, o_inst_we}, 32'd1);
      check("imem2_addr", o_inst_mem_addr, 32'h0000_0008);
      check("imem2_data", o_inst_mem_data, 32'hDDCC_BBAA);
      check("imem2_cnt",  {16'd0, o_frame_cnt}, 32'd5);
      realign();

      // Unknown command in IDLE
      send_byte(8'h09);
      @(negedge clk);
      check("idle_badcmd_err",   {30'd0, o_err}, 32'd1);
      check("idle_badcmd_ready", {31'd0, o_rx_ready}, 32'd1);
      realign();

      // REG with upper index bits set: 0xE3 -> index 3
      send_frame(80'h02_E3_78_56_34_12_E9, 7);
      @(negedge clk);
      check("reg2_we",   {31'd0, o_reg_we}, 32'd1);
      check("reg2_addr", {27'd0, o_load_reg_addr}, 32'd3);
      check("reg2_data", o_load_reg_data, 32'h1234_5678);
      check("reg2_cnt",  {16'd0, o_frame_cnt}, 32'd6);
      realign();

      repeat (2) realign();
      check("pass_inst_pulses", inst_pulses - base_inst, 32'd2);
      check("pass_reg_pulses",  reg_pulses - base_reg, 32'd2);

      // Reset after 5 bytes of an IMEM frame, then a full REG frame
      snap_inst = inst_pulses;
      send_frame(80'h01_04_00_00_00, 5);
      apply_reset();
      send_frame(80'h02_04_01_00_00_00_07, 7);
      @(negedge clk);
      check("postrst_reg_we",   {31'd0, o_reg_we}, 32'd1);
      check("postrst_reg_addr", {27'd0, o_load_reg_addr}, 32'd4);
      check("postrst_reg_data", o_load_reg_data, 32'h0000_0001);
      check("postrst_cnt",      {16'd0, o_frame_cnt}, 32'd1);
      check("postrst_err",      {30'd0, o_err}, 32'd0);
      realign();

      // HALT while in setup: counted no-op
      send_frame(80'h04_04, 2);
      @(negedge clk);
      check("halt_setup_cnt",   {16'd0, o_frame_cnt}, 32'd2);
      check("halt_setup_setup", {31'd0, o_setup}, 32'd1);
      check("halt_setup_strb",  {30'd0, o_inst_we, o_reg_we}, 32'd0);
      realign();

      repeat (2) realign();
      check("postrst_no_inst_we", inst_pulses - snap_inst, 32'd0);
    end

    check("strobe_shape", bad_strobes, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
